// File: rtl/seq_addsub.sv
// Digit-serial add/subtract unit: an N-bit operand pair is processed D bits per clock through one chained slice.
// Optional zero/ovf status flags are built only when SEQ_ADDSUB_FLAGS_EN is defined.
module seq_addsub #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] inp1,
    input  logic [N-1:0] inp2,
    input  logic         bin,
    output logic [N-1:0] sub,
    output logic         bo,
    output logic         busy,
    output logic         done,
    output logic         zero,
    output logic         ovf
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   sub_q, sub_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mode_q, mode_d;
    logic           chain_q, chain_d;
    logic           bo_q, bo_d;
    logic           accept;
    logic [D-1:0]   b_dig;
    logic [D:0]     sum;
`ifdef SEQ_ADDSUB_FLAGS_EN
    logic           a_msb_q, a_msb_d;
    logic           b_msb_q, b_msb_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
`endif

    // Subtraction runs as A + ~B + ~borrow, so the chain bit always holds a carry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        chain_d = chain_q;
        bo_d    = bo_q;
`ifdef SEQ_ADDSUB_FLAGS_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif

        b_dig  = mode_q ? b_q[D-1:0] : ~b_q[D-1:0];
        sum    = {1'b0, a_q[D-1:0]} + {1'b0, b_dig} + (D+1)'(chain_q);
        accept = start && ((state_q == IDLE) || (state_q == DONE));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> D;
                b_d     = b_q >> D;
                res_d   = (res_q >> D) | (N'(sum[D-1:0]) << (N - D));
                chain_d = sum[D];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    state_d = DONE;
                    sub_d   = res_d;
                    bo_d    = mode_q ? sum[D] : ~sum[D];
`ifdef SEQ_ADDSUB_FLAGS_EN
                    zero_d  = (res_d == '0);
                    ovf_d   = mode_q ? ((a_msb_q == b_msb_q) && (res_d[N-1] != a_msb_q))
                                     : ((a_msb_q != b_msb_q) && (res_d[N-1] != a_msb_q));
`endif
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            a_d     = inp1;
            b_d     = inp2;
            mode_d  = mode;
            chain_d = mode ? bin : ~bin;
            cnt_d   = '0;
            res_d   = '0;
`ifdef SEQ_ADDSUB_FLAGS_EN
            a_msb_d = inp1[N-1];
            b_msb_d = inp2[N-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            chain_q <= 1'b0;
            bo_q    <= 1'b0;
`ifdef SEQ_ADDSUB_FLAGS_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            chain_q <= chain_d;
            bo_q    <= bo_d;
`ifdef SEQ_ADDSUB_FLAGS_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sub  = sub_q;
    assign bo   = bo_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
`ifdef SEQ_ADDSUB_FLAGS_EN
    assign zero = zero_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed corner cases plus randomized operations
// checked against an integer-arithmetic reference model.
module tb_seq_addsub;

    localparam int N = 16;
    localparam int D = 4;
    localparam int K = N / D;
`ifdef SEQ_ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [N-1:0]  inp1;
    logic [N-1:0]  inp2;
    logic          bin;
    logic [N-1:0]  sub;
    logic          bo;
    logic          busy;
    logic          done;
    logic          zero;
    logic          ovf;

    int vectors     = 0;
    int miscompares = 0;

    seq_addsub #(.N(N), .D(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .inp1  (inp1),
        .inp2  (inp2),
        .bin   (bin),
        .sub   (sub),
        .bo    (bo),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Plain integer arithmetic; signed overflow taken as the exact result leaving the N-bit signed range.
    task automatic refModel(input logic [N-1:0] a, input logic [N-1:0] b, input logic m, input logic cin,
                            output logic [N-1:0] r, output logic c, output logic z, output logic v);
        longint ai, bi, ci, sa, sb, sr, ur;
        ai = longint'(a);
        bi = longint'(b);
        ci = longint'(cin);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            ur = ai + bi + ci;
            sr = sa + sb + ci;
            c  = (ur >= (64'sd1 <<< N));
        end else begin
            ur = ai - bi - ci;
            sr = sa - sb - ci;
            c  = (ai < bi + ci);
        end
        r = N'(ur);
        z = FLAGS && (r == '0);
        v = FLAGS && ((sr > ((64'sd1 <<< (N-1)) - 1)) || (sr < -(64'sd1 <<< (N-1))));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scrambleInputs();
        inp1 = N'($urandom);
        inp2 = N'($urandom);
        mode = 1'($urandom);
        bin  = 1'($urandom);
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, "_sub"},  sub,  '0);
        checkOutput({tag, "_bo"},   bo,   0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_zero"}, zero, 0);
        checkOutput({tag, "_ovf"},  ovf,  0);
    endtask

    // One full operation from the IDLE state; pokeCycle > 0 re-pulses start with junk operands mid-RUN.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                                 input logic cin, input int pokeCycle);
        logic [N-1:0] er;
        logic ec, ez, ev;
        int lat;
        refModel(a, b, m, cin, er, ec, ez, ev);
        start = 1'b1;
        inp1  = a;
        inp2  = b;
        mode  = m;
        bin   = cin;
        tick();
        start = 1'b0;
        scrambleInputs();
        lat = 1;
        while (done !== 1'b1 && lat <= 20) begin
            checkOutput("busy_run", busy, 1);
            if (lat == pokeCycle) begin
                start = 1'b1;
                scrambleInputs();
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        checkOutput("latency", lat, K + 1);
        checkOutput("busy_done", busy, 0);
        checkOutput("result", sub, er);
        checkOutput("bo", bo, ec);
        checkOutput("zero", zero, ez);
        checkOutput("ovf", ovf, ev);
        tick();
        checkOutput("done_single", done, 0);
        checkOutput("result_held", sub, er);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] er1, er2;
        logic ec1, ez1, ev1, ec2, ez2, ev2;
        int lat, gap, saw_done;

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        inp1  = '0;
        inp2  = '0;
        bin   = 1'b0;
        repeat (3) tick();
        checkAllReset("reset");
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", busy, 0);

        $display("[TB] directed operations");
        applyStimulus(16'h1234, 16'h0234, 1'b0, 1'b0, 0);
        applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b1, 0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b1, 1'b0, 0);
        applyStimulus(16'h0005, 16'h0005, 1'b0, 1'b1, 0);
        applyStimulus(16'hABCD, 16'h1234, 1'b0, 1'b0, 2);

        $display("[TB] reset during RUN");
        start = 1'b1;
        inp1  = 16'hF00D;
        inp2  = 16'h0001;
        mode  = 1'b0;
        bin   = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkAllReset("abort");
        saw_done = 0;
        repeat (8) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        checkOutput("abort_no_done", saw_done, 0);
        applyStimulus(16'h4321, 16'h1111, 1'b1, 1'b0, 0);

        $display("[TB] back-to-back with start held");
        refModel(16'h1000, 16'h0FFF, 1'b0, 1'b0, er1, ec1, ez1, ev1);
        refModel(16'h8000, 16'h8000, 1'b1, 1'b0, er2, ec2, ez2, ev2);
        start = 1'b1;
        inp1  = 16'h1000;
        inp2  = 16'h0FFF;
        mode  = 1'b0;
        bin   = 1'b0;
        tick();
        inp1 = 16'h8000;
        inp2 = 16'h8000;
        mode = 1'b1;
        lat  = 1;
        while (done !== 1'b1 && lat <= 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b_latency1", lat, K + 1);
        checkOutput("b2b_result1", sub, er1);
        checkOutput("b2b_bo1", bo, ec1);
        checkOutput("b2b_zero1", zero, ez1);
        checkOutput("b2b_ovf1", ovf, ev1);
        tick();
        start = 1'b0;
        scrambleInputs();
        gap = 1;
        while (done !== 1'b1 && gap <= 20) begin
            tick();
            gap++;
        end
        checkOutput("b2b_gap", gap, K + 1);
        checkOutput("b2b_result2", sub, er2);
        checkOutput("b2b_bo2", bo, ec2);
        checkOutput("b2b_zero2", zero, ez2);
        checkOutput("b2b_ovf2", ovf, ev2);
        tick();
        checkOutput("b2b_idle", busy, 0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                          (i % 4 == 0) ? int'($urandom_range(1, K)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
